mdu_hilo_ctrl: RTL

Multiply-unit controller and HI/LO register file for the MIPS32 EX stage. Accepts MULT/MULTU/MTHI/MTLO from the pipeline, converts signed operands to magnitude plus sign flag, drives the 32x32 unsigned multi-cycle multiplier through its start/finish handshake, stalls the pipeline while a multiply is in flight, and writes the 64-bit product into HI/LO. HI/LO values are exported continuously for MFHI/MFLO.

---
 rtl/mdu_hilo_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mdu_hilo_ctrl.sv
// MIPS32 EX-stage multiply controller and HI/LO register file: issues MULT/MULTU to an
// external multi-cycle multiplier, holds the pipeline while it runs, and applies MTHI/MTLO in one cycle.
module mdu_hilo_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        timeout,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_sign_diff,
    input  logic        mul_finish,
    input  logic [63:0] mul_result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    // Last WAIT cycle index; the counter is cleared in ISSUE so WAIT lasts TIMEOUT cycles at most.
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sd_q, sd_d;
    logic        drop_q, drop_d;
    logic        to_q, to_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [31:0] rs_mag;
    logic [31:0] rt_mag;

    // Two's-complement negate; 0x80000000 maps to itself, which is the right unsigned magnitude.
    assign rs_mag = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    assign rt_mag = rt_val[31] ? (~rt_val + 32'd1) : rt_val;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        sd_d    = sd_q;
        drop_d  = drop_q;
        to_d    = to_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (op_valid) begin
                    unique case (op)
                        OP_MULT: begin
                            a_d     = rs_mag;
                            b_d     = rt_mag;
                            sd_d    = rs_val[31] ^ rt_val[31];
                            state_d = ISSUE;
                        end
                        OP_MULTU: begin
                            a_d     = rs_val;
                            b_d     = rt_val;
                            sd_d    = 1'b0;
                            state_d = ISSUE;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                    endcase
                end
            end

            ISSUE: begin
                cnt_d   = 4'd0;
                drop_d  = flush;
                state_d = WAIT;
            end

            WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (flush) begin
                    drop_d = 1'b1;
                end
                // The multiplier cannot be aborted, so a flushed result is still awaited, just not written.
                if (mul_finish) begin
                    if (!(drop_q || flush)) begin
                        {hi_d, lo_d} = mul_result;
                    end
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sd_q    <= 1'b0;
            drop_q  <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sd_q    <= sd_d;
            drop_q  <= drop_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall         = (state_q != IDLE);
    assign mul_start     = (state_q == ISSUE);
    assign hi            = hi_q;
    assign lo            = lo_q;
    assign timeout       = to_q;
    assign mul_a         = a_q;
    assign mul_b         = b_q;
    assign mul_sign_diff = sd_q;

endmodule
